dmem_pipe_ctrl: RTL



---
 rtl/dmem_pipe_if.sv | 40 ++++
 rtl/dmem_pipe_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_pipe_if.sv
// Load/store request and response bundle between a core and dmem_pipe_ctrl.
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high; req_we/req_func3/req_addr/req_wdata must be stable
// whenever req_valid is high. A requester may hold req_valid high across
// cycles until it sees req_ready. rsp_valid is a single-cycle pulse with no
// back-pressure; rsp_rdata and rsp_err are meaningful only while it is high.
//
// Signals:
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_func3            RISC-V funct3 (access size and signedness)
//   req_addr             byte address
//   req_wdata            store data, LSB-aligned
//   rsp_valid            response pulse
//   rsp_rdata            extended load data (0 for stores and faults)
//   rsp_err              access faulted
interface dmem_pipe_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [2:0]      req_func3;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_func3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_func3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_pipe_ctrl.sv
// Data-memory subsystem for the load/store path: accepts one request at a
// time, waits LATENCY cycles in ACCESS, then pulses a response. Faulting
// requests (misaligned, out of range, illegal funct3) skip ACCESS and respond
// one cycle after acceptance without touching the array.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        dmem_pipe_if slave side (request/response)
//   busy       high while in ACCESS
//   state_dbg  current FSM state encoding (IDLE=0, ACCESS=1, RESP=2)
module dmem_pipe_ctrl #(
   parameter int unsigned     XLEN      = 32,
   parameter int unsigned     DEPTH     = 1024,
   parameter int unsigned     LATENCY   = 1,
   parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   dmem_pipe_if.slave bus,
   output logic       busy,
   output logic [1:0] state_dbg
);
   localparam int unsigned   NB   = XLEN / 8;
   localparam int unsigned   LB   = $clog2(NB);
   localparam int unsigned   AW   = $clog2(DEPTH);
   localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH) * (XLEN+1)'(NB);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t          state, state_nx;
   logic [1:0]      cnt;
   logic            l_we, l_uns;
   logic [1:0]      l_size;
   logic [AW-1:0]   l_idx;
   logic [LB-1:0]   l_lane;
   logic [XLEN-1:0] l_wdata;
   logic [XLEN-1:0] rdata_q;
   logic            err_q;

   logic [XLEN-1:0] mem [DEPTH];

   // Acceptance-time decode
   logic            accept, f3_ok, mis, oor, fault;
   logic [2:0]      amask;
   logic [XLEN-1:0] off;

   always_comb begin
      f3_ok = 1'b0;
      amask = 3'b000;
      case (bus.req_func3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b011:                 f3_ok = (XLEN == 64);
         3'b100, 3'b101:         f3_ok = !bus.req_we;
         3'b110:                 f3_ok = (XLEN == 64) && !bus.req_we;
         default:                f3_ok = 1'b0;
      endcase
      case (bus.req_func3[1:0])
         2'd0:    amask = 3'b000;
         2'd1:    amask = 3'b001;
         2'd2:    amask = 3'b011;
         default: amask = 3'b111;
      endcase
      off    = bus.req_addr - BASE_ADDR;
      mis    = |(bus.req_addr[2:0] & amask);
      oor    = (bus.req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
      fault  = !f3_ok || mis || oor;
      accept = bus.req_valid && bus.req_ready;
   end

   // Lane steering for the latched request
   logic [7:0]      mask8;
   logic [2:0]      smask;
   logic [NB-1:0]   be;
   logic [XLEN-1:0] wrep, rshift, rext;
   int unsigned     nbits;
   logic            sbit;

   always_comb begin
      mask8 = 8'h01;
      smask = 3'b000;
      case (l_size)
         2'd0:    begin mask8 = 8'h01; smask = 3'b000; end
         2'd1:    begin mask8 = 8'h03; smask = 3'b001; end
         2'd2:    begin mask8 = 8'h0F; smask = 3'b011; end
         default: begin mask8 = 8'hFF; smask = 3'b111; end
      endcase
      be = NB'(mask8) << l_lane;
      // Each lane takes the store byte at its position within the access,
      // so the enabled lanes see the LSB-aligned data in order.
      wrep = '0;
      for (int b = 0; b < NB; b++) begin
         wrep[8*b +: 8] = l_wdata[8*(b & 32'(smask)) +: 8];
      end
      rshift = mem[l_idx] >> {l_lane, 3'b000};
      nbits  = 8 << l_size;
      if (nbits > XLEN) nbits = XLEN;
      sbit   = !l_uns && rshift[nbits-1];
      rext   = '0;
      for (int i = 0; i < XLEN; i++) begin
         rext[i] = (i < nbits) ? rshift[i] : sbit;
      end
   end

   // FSM next state and outputs
   always_comb begin
      state_nx      = state;
      bus.req_ready = 1'b1;
      bus.rsp_valid = 1'b0;
      busy          = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) state_nx = fault ? RESP : ACCESS;
         end
         ACCESS: begin
            bus.req_ready = 1'b0;
            busy          = 1'b1;
            if (cnt == 2'd0) state_nx = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.req_valid) state_nx = fault ? RESP : ACCESS;
            else               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
      bus.rsp_err   = bus.rsp_valid && err_q;
      state_dbg     = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         l_we    <= 1'b0;
         l_uns   <= 1'b0;
         l_size  <= 2'd0;
         l_idx   <= '0;
         l_lane  <= '0;
         l_wdata <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            l_we    <= bus.req_we;
            l_uns   <= bus.req_func3[2];
            l_size  <= bus.req_func3[1:0];
            l_idx   <= off[LB +: AW];
            l_lane  <= off[LB-1:0];
            l_wdata <= bus.req_wdata;
            cnt     <= 2'(LATENCY - 1);
            if (fault) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end else if (state == ACCESS) begin
            if (cnt != 2'd0) begin
               cnt <= cnt - 2'd1;
            end else begin
               err_q   <= 1'b0;
               rdata_q <= l_we ? '0 : rext;
            end
         end
      end
   end

   // Store commit on the edge leaving ACCESS. An async reset forces IDLE,
   // so an abandoned store never reaches this condition.
   always_ff @(posedge clk) begin
      if (state == ACCESS && cnt == 2'd0 && l_we) begin
         for (int b = 0; b < NB; b++) begin
            if (be[b]) mem[l_idx][8*b +: 8] <= wrep[8*b +: 8];
         end
      end
   end
endmodule
